// File: rtl/wb_pkg.sv
// Shared definitions for the wb_timer register block: bus widths, bus FSM
// states, register offsets and CTRL bit positions.
package wb_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_t;

  localparam logic [4:0] WB_TMR_CTRL   = 5'h00;
  localparam logic [4:0] WB_TMR_LOAD   = 5'h04;
  localparam logic [4:0] WB_TMR_COUNT  = 5'h08;
  localparam logic [4:0] WB_TMR_STATUS = 5'h0C;
  localparam logic [4:0] WB_TMR_PRESC  = 5'h10;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // CTRL as seen on the bus: three live bits, everything above reads 0
  function automatic logic [WORD_SIZE-1:0] ctrl_word(input logic [2:0] c);
    return {{(WORD_SIZE-3){1'b0}}, c[CTRL_IE], c[CTRL_AR], c[CTRL_EN]};
  endfunction

endpackage

// File: rtl/timer_counter.sv
// timer_counter: COUNT register with optional prescaler, expiry and reload.
// The prescaler exists only when WB_TIMER_PRESCALER_EN is defined; otherwise
// the counter ticks every cycle.
module timer_counter
  import wb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_auto_reload,
  input  logic [WORD_SIZE-1:0] i_load_val,
  input  logic                 i_wr_count,
  input  logic [WORD_SIZE-1:0] i_wr_val,
`ifdef WB_TIMER_PRESCALER_EN
  input  logic [15:0]          i_presc,
  input  logic                 i_presc_restart,
`endif
  output logic [WORD_SIZE-1:0] o_count,
  output logic                 o_expire
);

  logic [WORD_SIZE-1:0] r_count;
  logic                 w_tick;

`ifdef WB_TIMER_PRESCALER_EN
  logic [15:0] r_pcnt;

  assign w_tick = (r_pcnt == i_presc);

  // Prescaler divider: one tick every PRESC+1 cycles, restarted by CTRL/PRESC writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_pcnt <= '0;
    else if (i_presc_restart || w_tick) r_pcnt <= '0;
    else                                r_pcnt <= r_pcnt + 16'd1;
  end
`else
  assign w_tick = 1'b1;
`endif

  // A tick that finds the count at zero is an expiry; a bus load in the same
  // cycle takes precedence over the whole tick action.
  assign o_expire = i_enable & w_tick & (r_count == '0) & ~i_wr_count;
  assign o_count  = r_count;

  // Count register: bus load wins, else decrement, reload or hold at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_wr_count) begin
      r_count <= i_wr_val;
    end else if (i_enable && w_tick) begin
      if (r_count != '0)      r_count <= r_count - WORD_SIZE'(1);
      else if (i_auto_reload) r_count <= i_load_val;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone-style responder with a 32-bit down-counting timer and a
// level interrupt (STATUS.expired & CTRL.irq_en).
// Define WB_TIMER_PRESCALER_EN to add the 16-bit PRESC register at 0x10.
module wb_timer
  import wb_pkg::*;
#(
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                   WAIT_STATES = 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [ADDR_SIZE-1:0] S_wb_addr,
  input  logic                 S_wb_cs,
  input  logic                 S_wb_we,
  input  logic [WORD_SIZE-1:0] S_wb_wdata,
  output logic [WORD_SIZE-1:0] S_wb_rdata,
  output logic                 S_wb_ack,
  output logic                 Irq
);

  wb_state_t            r_state, w_state_nxt;
  logic [3:0]           r_wcnt;
  logic                 w_hit, w_capture;
  logic [2:0]           r_widx;
  logic                 r_we;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [4:0]           w_off;
  logic                 w_wr, w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status;
  logic [2:0]           r_ctrl;
  logic [WORD_SIZE-1:0] r_load;
  logic                 r_expired;
  logic [WORD_SIZE-1:0] w_count;
  logic                 w_expire;
  logic                 w_unused;

  // Byte lanes within a word are not decoded.
  assign w_unused = ^S_wb_addr[1:0];
  assign w_hit    = S_wb_cs & (S_wb_addr[ADDR_SIZE-1:5] == BASE_ADDR[ADDR_SIZE-1:5]);
  assign w_off    = {r_widx, 2'b00};

  // Bus FSM next state, capture strobe and acknowledge
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    S_wb_ack    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) w_state_nxt = ACK;
          else                  w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!S_wb_cs)                             w_state_nxt = IDLE;
        else if (r_wcnt == 4'(WAIT_STATES - 1))   w_state_nxt = ACK;
      end
      ACK: begin
        S_wb_ack    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus FSM state register and wait-state counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture)            r_wcnt <= '0;
      else if (r_state == WAIT) r_wcnt <= r_wcnt + 4'd1;
    end
  end

  // Request capture; only consumed in ACK, which is unreachable without a capture
  always_ff @(posedge Clk) begin
    if (w_capture) begin
      r_widx  <= S_wb_addr[4:2];
      r_we    <= S_wb_we;
      r_wdata <= S_wb_wdata;
    end
  end

  assign w_wr        = (r_state == ACK) & r_we;
  assign w_wr_ctrl   = w_wr & (w_off == WB_TMR_CTRL);
  assign w_wr_load   = w_wr & (w_off == WB_TMR_LOAD);
  assign w_wr_count  = w_wr & (w_off == WB_TMR_COUNT);
  assign w_wr_status = w_wr & (w_off == WB_TMR_STATUS);

  // CTRL: a bus write overrides the one-shot auto-clear of enable
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                              r_ctrl <= '0;
    else if (w_wr_ctrl)                      r_ctrl <= r_wdata[2:0];
    else if (w_expire && !r_ctrl[CTRL_AR])   r_ctrl[CTRL_EN] <= 1'b0;
  end

  // LOAD register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)         r_load <= '0;
    else if (w_wr_load) r_load <= r_wdata;
  end

  // STATUS.expired: a new expiry beats a simultaneous write-one-to-clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                         r_expired <= 1'b0;
    else if (w_expire)                  r_expired <= 1'b1;
    else if (w_wr_status && r_wdata[0]) r_expired <= 1'b0;
  end

`ifdef WB_TIMER_PRESCALER_EN
  logic [15:0] r_presc;
  logic        w_wr_presc;

  assign w_wr_presc = w_wr & (w_off == WB_TMR_PRESC);

  // PRESC register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)          r_presc <= '0;
    else if (w_wr_presc) r_presc <= r_wdata[15:0];
  end
`endif

  timer_counter u_counter (
    .i_clk           (Clk),
    .i_rst_n         (Rst_n),
    .i_enable        (r_ctrl[CTRL_EN]),
    .i_auto_reload   (r_ctrl[CTRL_AR]),
    .i_load_val      (r_load),
    .i_wr_count      (w_wr_count),
    .i_wr_val        (r_wdata),
`ifdef WB_TIMER_PRESCALER_EN
    .i_presc         (r_presc),
    .i_presc_restart (w_wr_ctrl | w_wr_presc),
`endif
    .o_count         (w_count),
    .o_expire        (w_expire)
  );

  assign Irq = r_expired & r_ctrl[CTRL_IE];

  // Read data, driven only while acknowledging; unmapped offsets read 0
  always_comb begin
    S_wb_rdata = '0;
    if (r_state == ACK) begin
      case (w_off)
        WB_TMR_CTRL:   S_wb_rdata = ctrl_word(r_ctrl);
        WB_TMR_LOAD:   S_wb_rdata = r_load;
        WB_TMR_COUNT:  S_wb_rdata = w_count;
        WB_TMR_STATUS: S_wb_rdata = {{(WORD_SIZE-1){1'b0}}, r_expired};
`ifdef WB_TIMER_PRESCALER_EN
        WB_TMR_PRESC:  S_wb_rdata = {{(WORD_SIZE-16){1'b0}}, r_presc};
`endif
        default:       S_wb_rdata = '0;
      endcase
    end
  end

endmodule
